// File: rtl/axi_master_pkg.sv
// axi_master_pkg: shared types and constants for the single-outstanding AXI3
// master. Holds the FSM state enum, AXI burst/response encodings and a helper
// that flags command encodings this master refuses to put on the bus.
package axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Reserved burst type or beats wider than the 32-bit data bus.
    function automatic logic cmd_unsupported(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b11) || (size > 3'd2);
    endfunction

endpackage

// File: rtl/axi_watchdog.sv
// axi_watchdog: idle-cycle counter guarding the non-IDLE states of axi_master.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear        restart the count (state entry or any channel handshake)
//   enable       count only while a transaction is in flight
//   expired      count has reached TIMEOUT-1 while enabled
module axi_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (clear || !enable)
            cnt_q <= '0;
        else if (cnt_q != LIMIT)
            cnt_q <= cnt_q + 1'b1;
    end

    assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/axi_master.sv
// axi_master: bridges a command / write-stream / read-stream interface onto an
// AXI3 master port with exactly one transaction in flight. Each command ends
// with a one-cycle done pulse carrying the id and the final response.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_*                      command handshake and fields (write=1 -> write)
//   wr_*                       write-data source stream (passed to W channel)
//   rd_*                       read-data sink stream (fed from R channel)
//   done_*                     completion pulse, no back-pressure
//   aw*/w*/b*/ar*/r*           AXI3 master channels
module axi_master
    import axi_master_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_id,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [2:0]  cmd_size,
    input  logic [1:0]  cmd_burst,

    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,

    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_resp,
    output logic        rd_last,

    output logic        done_valid,
    output logic [3:0]  done_id,
    output logic [1:0]  done_resp,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    state_t      state_q, state_d;
    logic [3:0]  lat_id, lat_len;
    logic [31:0] lat_addr;
    logic [2:0]  lat_size;
    logic [1:0]  lat_burst;
    logic [3:0]  beat_q;
    logic [1:0]  resp_q;
    logic        id_err_q;

    logic        bad_cmd, at_len, expired;
    logic        hs_cmd, hs_aw, hs_w, hs_b, hs_ar, hs_r, r_end;
    logic [1:0]  r_acc;
    logic        r_id_err, r_err;

    assign bad_cmd = cmd_unsupported(lat_burst, lat_size);
    assign at_len  = (beat_q == lat_len);

    // Read response bookkeeping for the current R beat: running maximum of
    // rresp, sticky id mismatch, and a last-beat/beat-count disagreement check.
    assign r_acc    = (rresp > resp_q) ? rresp : resp_q;
    assign r_id_err = id_err_q || (rid != lat_id);
    assign r_err    = r_id_err || (rlast != at_len);

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wr_ready   = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        hs_cmd     = 1'b0;
        hs_aw      = 1'b0;
        hs_w       = 1'b0;
        hs_b       = 1'b0;
        hs_ar      = 1'b0;
        hs_r       = 1'b0;
        r_end      = 1'b0;
        // Expiry silences every channel of the owning state, so no handshake
        // can race the abort.
        case (state_q)
            IDLE: begin
                cmd_ready = !reset;
                hs_cmd    = cmd_valid && !reset;
                if (hs_cmd)
                    state_d = cmd_write ? WADDR : RADDR;
            end
            WADDR: begin
                if (bad_cmd || expired)
                    state_d = DONE;
                else begin
                    awvalid = 1'b1;
                    hs_aw   = awready;
                    if (hs_aw)
                        state_d = WDATA;
                end
            end
            WDATA: begin
                if (expired)
                    state_d = DONE;
                else begin
                    wvalid   = wr_valid;
                    wr_ready = wready;
                    wlast    = at_len;
                    hs_w     = wr_valid && wready;
                    if (hs_w && at_len)
                        state_d = WRESP;
                end
            end
            WRESP: begin
                if (expired)
                    state_d = DONE;
                else begin
                    bready = 1'b1;
                    hs_b   = bvalid;
                    if (hs_b)
                        state_d = DONE;
                end
            end
            RADDR: begin
                if (bad_cmd || expired)
                    state_d = DONE;
                else begin
                    arvalid = 1'b1;
                    hs_ar   = arready;
                    if (hs_ar)
                        state_d = RDATA;
                end
            end
            RDATA: begin
                if (expired)
                    state_d = DONE;
                else begin
                    rready   = rd_ready;
                    rd_valid = rvalid;
                    rd_last  = rlast;
                    hs_r     = rvalid && rd_ready;
                    r_end    = hs_r && (rlast || at_len);
                    if (r_end)
                        state_d = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_id    <= '0;
            lat_addr  <= '0;
            lat_len   <= '0;
            lat_size  <= '0;
            lat_burst <= '0;
            beat_q    <= '0;
            resp_q    <= RESP_OKAY;
            id_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs_cmd) begin
                lat_id    <= cmd_id;
                lat_addr  <= cmd_addr;
                lat_len   <= cmd_len;
                lat_size  <= cmd_size;
                lat_burst <= cmd_burst;
                beat_q    <= '0;
                resp_q    <= RESP_OKAY;
                id_err_q  <= 1'b0;
            end else if ((state_q == WADDR || state_q == RADDR) && bad_cmd) begin
                resp_q <= RESP_SLVERR;
            end else if (expired) begin
                resp_q <= RESP_DECERR;
            end else if (hs_w) begin
                beat_q <= beat_q + 1'b1;
            end else if (hs_b) begin
                resp_q <= (bid != lat_id) ? RESP_SLVERR : bresp;
            end else if (hs_r) begin
                beat_q   <= beat_q + 1'b1;
                id_err_q <= r_id_err;
                resp_q   <= (r_end && r_err) ? RESP_SLVERR : r_acc;
            end
        end
    end

    axi_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state_d != state_q) || hs_aw || hs_w || hs_b || hs_ar || hs_r),
        .enable  ((state_q != IDLE) && (state_q != DONE)),
        .expired (expired)
    );

    assign awid      = lat_id;
    assign awaddr    = lat_addr;
    assign awlen     = lat_len;
    assign awsize    = lat_size;
    assign awburst   = lat_burst;
    assign arid      = lat_id;
    assign araddr    = lat_addr;
    assign arlen     = lat_len;
    assign arsize    = lat_size;
    assign arburst   = lat_burst;
    assign wid       = lat_id;
    assign wdata     = wr_data;
    assign wstrb     = wr_strb;
    assign rd_data   = rdata;
    assign rd_resp   = rresp;
    assign done_id   = lat_id;
    assign done_resp = resp_q;

endmodule

// File: tb/tb_axi_master.sv
module tb_axi_master;
    import axi_master_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id, cmd_len;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;
    logic [3:0]  awid, awlen, wid, bid, arid, arlen, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    axi_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_resp(rd_resp), .rd_last(rd_last),
        .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(posedge clk) if (done_valid) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One command plus how the slave answers it, and what must come back.
    typedef struct {
        logic        wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  sid;       // bid / rid returned by the slave
        logic [1:0]  sresp;     // bresp, or rresp on read beat index 1
        int          rlast_at;  // read beat index carrying rlast
        logic [1:0]  exp_resp;
        int          exp_beats;
        logic        exp_addr;  // an AW/AR valid must appear
    } vec_t;

    vec_t tbl[11];

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0;
        cmd_size = 0; cmd_burst = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0;
        awready = 0; wready = 0; arready = 0;
        bid = 0; bresp = 0; bvalid = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input string tag);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
        cmd_len = len; cmd_size = size; cmd_burst = burst;
        #1 check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int  wb, rb;
        bit  done_seen, addr_seen;
        string t;
        t = $sformatf("v%0d", k);
        wb = 0; rb = 0; done_seen = 0; addr_seen = 0;
        send_cmd(v.wr, v.id, v.addr, v.len, v.size, v.burst, t);
        for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
            @(negedge clk);
            cmd_valid = 0;
            awready = 1; arready = 1; wready = 1; wr_valid = 1; rd_ready = 1;
            wr_data = 32'h1000_0000 + 32'(wb); wr_strb = 4'hF;
            bvalid = v.wr && (wb > int'(v.len)); bid = v.sid; bresp = v.sresp;
            rvalid = 1; rid = v.sid; rdata = 32'hD000_0000 + 32'(rb);
            rresp = (rb == 1) ? v.sresp : RESP_OKAY;
            rlast = (rb == v.rlast_at);
            #1;
            if ((awvalid || arvalid) && !addr_seen) begin
                addr_seen = 1;
                check({t, " addr valids"}, 64'({awvalid, arvalid}), 64'({v.wr, !v.wr}));
                if (v.wr)
                    check({t, " aw fields"}, 64'({awid, awaddr, awlen, awsize, awburst}),
                          64'({v.id, v.addr, v.len, v.size, v.burst}));
                else
                    check({t, " ar fields"}, 64'({arid, araddr, arlen, arsize, arburst}),
                          64'({v.id, v.addr, v.len, v.size, v.burst}));
            end
            if (wvalid && wready) begin
                check($sformatf("%s w%0d last/data/id", t, wb), 64'({wlast, wdata, wid}),
                      64'({(wb == int'(v.len)), 32'h1000_0000 + 32'(wb), v.id}));
                wb++;
            end
            if (rd_valid && rd_ready) begin
                check($sformatf("%s r%0d last/data", t, rb), 64'({rd_last, rd_data}),
                      64'({(rb == v.rlast_at), 32'hD000_0000 + 32'(rb)}));
                rb++;
            end
            if (done_valid) begin
                done_seen = 1;
                check({t, " done id/resp"}, 64'({done_id, done_resp}), 64'({v.id, v.exp_resp}));
            end
        end
        check({t, " done seen"}, 64'(done_seen), 64'd1);
        check({t, " beats"}, 64'(v.wr ? wb : rb), 64'(v.exp_beats));
        check({t, " addr phase"}, 64'(addr_seen), 64'(v.exp_addr));
        idle_inputs();
        @(negedge clk);
        #1 check({t, " back idle"}, 64'({done_valid, cmd_ready}), 64'b01);
    endtask

    initial begin
        int  cyc, done_at, snap;
        bit  hs_seen;

        //          wr    id     addr      len   size  burst        sid    sresp  rl  exp    bt ad
        tbl[0]  = '{1'b1, 4'd3,  32'h10,   4'd3, 3'd2, BURST_INCR,  4'd3,  2'b00, 0,  2'b00, 4, 1'b1};
        tbl[1]  = '{1'b0, 4'd5,  32'h20,   4'd0, 3'd2, BURST_FIXED, 4'd5,  2'b00, 0,  2'b00, 1, 1'b1};
        tbl[2]  = '{1'b0, 4'd1,  32'h40,   4'd3, 3'd2, BURST_INCR,  4'd1,  2'b00, 1,  2'b10, 2, 1'b1};
        tbl[3]  = '{1'b1, 4'd2,  32'h80,   4'd0, 3'd1, BURST_INCR,  4'd7,  2'b00, 0,  2'b10, 1, 1'b1};
        tbl[4]  = '{1'b1, 4'd9,  32'h100,  4'd1, 3'd2, BURST_INCR,  4'd9,  2'b01, 0,  2'b01, 2, 1'b1};
        tbl[5]  = '{1'b0, 4'd4,  32'h200,  4'd2, 3'd2, BURST_INCR,  4'd4,  2'b01, 2,  2'b01, 3, 1'b1};
        tbl[6]  = '{1'b0, 4'd6,  32'h300,  4'd1, 3'd2, BURST_INCR,  4'd9,  2'b00, 1,  2'b10, 2, 1'b1};
        tbl[7]  = '{1'b0, 4'd8,  32'h400,  4'd1, 3'd0, BURST_INCR,  4'd8,  2'b00, 15, 2'b10, 2, 1'b1};
        tbl[8]  = '{1'b1, 4'd7,  32'h500,  4'd1, 3'd2, 2'b11,       4'd7,  2'b00, 0,  2'b10, 0, 1'b0};
        tbl[9]  = '{1'b0, 4'd12, 32'h600,  4'd0, 3'd3, BURST_INCR,  4'd12, 2'b00, 0,  2'b10, 0, 1'b0};
        tbl[10] = '{1'b0, 4'd10, 32'h700,  4'd3, 3'd2, BURST_WRAP,  4'd10, 2'b11, 3,  2'b11, 4, 1'b1};

        // Reset with every input pushing for activity: all control outputs stay low.
        idle_inputs();
        reset = 1;
        cmd_valid = 1; wr_valid = 1; rd_ready = 1; wready = 1; rvalid = 1; rlast = 1;
        bvalid = 1; awready = 1; arready = 1;
        #2;
        check("reset outputs",
              64'({cmd_ready, awvalid, wvalid, wr_ready, wlast, bready, arvalid, rready,
                   rd_valid, rd_last, done_valid}), 64'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1 check("post-reset cmd_ready", 64'(cmd_ready), 64'd1);

        for (int k = 0; k < 11; k++) run_vec(k, tbl[k]);

        // Unsupported burst: done two cycles after accept, no AXI valid.
        send_cmd(1'b0, 4'd7, 32'h0, 4'd0, 3'd2, 2'b11, "badburst");
        @(negedge clk);
        cmd_valid = 0;
        #1 check("badburst c1 valids/done", 64'({awvalid, arvalid, done_valid}), 64'd0);
        @(negedge clk);
        #1 check("badburst c2 done", 64'({awvalid, arvalid, done_valid, done_id, done_resp}),
                 64'({1'b0, 1'b0, 1'b1, 4'd7, 2'b10}));

        // B never arrives: abort 16 edges after the last W handshake.
        send_cmd(1'b1, 4'd2, 32'h30, 4'd1, 3'd2, BURST_INCR, "timeout");
        @(negedge clk);
        cmd_valid = 0; awready = 1; wready = 1; wr_valid = 1; wr_strb = 4'hF;
        hs_seen = 0; cyc = 0;
        while (!hs_seen && cyc < 20) begin
            #1;
            if (wvalid && wready && wlast) hs_seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("timeout last W seen", 64'(hs_seen), 64'd1);
        done_at = -1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            @(negedge clk);
            #1;
            if (i == 15) check("timeout bready before expiry", 64'(bready), 64'd1);
            if (i == 16) check("timeout bready at expiry", 64'(bready), 64'd0);
            if (done_valid) begin
                done_at = i;
                check("timeout resp", 64'(done_resp), 64'(RESP_DECERR));
            end
        end
        check("timeout done cycle", 64'(done_at), 64'd17);
        idle_inputs();

        // Reset during W beat 2 of 4: channels drop at once, no done pulse.
        send_cmd(1'b1, 4'd1, 32'h50, 4'd3, 3'd2, BURST_INCR, "rstmid");
        @(negedge clk);
        cmd_valid = 0; awready = 1; wready = 1; wr_valid = 1;
        cyc = 0; hs_seen = 0;
        while (!hs_seen && cyc < 20) begin
            #1;
            if (wvalid && wready) hs_seen = 1;
            @(negedge clk);
            cyc++;
        end
        #1 check("rstmid beat2 presented", 64'(wvalid), 64'd1);
        snap = done_cnt;
        reset = 1;
        #1 check("rstmid valids drop", 64'({wvalid, awvalid, wr_ready, wlast}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        idle_inputs();
        #1 check("rstmid cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("rstmid no done", 64'(done_cnt), 64'(snap));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
